// File: rtl/math_computer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : math_computer_pkg                                         |
// | Purpose  : Shared types and constants for the math computer engine:  |
// |            FSM state type, default operand width and a helper that   |
// |            returns the result width (twice the operand width).       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package math_computer_pkg;

    localparam int DATASIZE_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    // a*b + c with N-bit unsigned operands always fits in 2N bits.
    function automatic int result_width(input int datasize);
        return 2 * datasize;
    endfunction

endpackage
`default_nettype wire

// File: rtl/math_computer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : math_computer_if                                          |
// | Purpose  : Operand input channel (valid/ready + a, b, c) and result  |
// |            output channel (valid/ready + result) of the engine.      |
// | Modports : slave  - engine side (responder in, initiator out)        |
// |            master - producer/consumer side                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface math_computer_if
    import math_computer_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEFAULT
);
    logic                                input_valid;
    logic                                input_ready;
    logic [DATASIZE-1:0]                 a;
    logic [DATASIZE-1:0]                 b;
    logic [DATASIZE-1:0]                 c;
    logic                                output_valid;
    logic                                output_ready;
    logic [result_width(DATASIZE)-1:0]   result;

    modport slave (
        input  input_valid, a, b, c, output_ready,
        output input_ready, output_valid, result
    );

    modport master (
        output input_valid, a, b, c, output_ready,
        input  input_ready, output_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/math_computer_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : math_computer_mult_seq                                    |
// | Purpose  : Iterative shift-add datapath computing a*b + c.           |
// |            load : capture a, b; seed accumulator with c; clear count |
// |            step : one multiply step (adds shifted a when b bit set)  |
// |            acc  : accumulator value                                  |
// |            done : asserted on the step that completes the product    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module math_computer_mult_seq
    import math_computer_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEFAULT
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              load,
    input  wire logic                              step,
    input  wire logic [DATASIZE-1:0]               a,
    input  wire logic [DATASIZE-1:0]               b,
    input  wire logic [DATASIZE-1:0]               c,
    output logic      [result_width(DATASIZE)-1:0] acc,
    output logic                                   done
);
    localparam int RW = result_width(DATASIZE);
    localparam int CW = (DATASIZE > 1) ? $clog2(DATASIZE) : 1;

    // Multiplicand shifts left and multiplier shifts right each step, so
    // the step always examines bit 0 and adds an already-aligned operand.
    logic [RW-1:0]       mcand_q,  mcand_d;
    logic [DATASIZE-1:0] mplier_q, mplier_d;
    logic [RW-1:0]       acc_q,    acc_d;
    logic [CW-1:0]       cnt_q,    cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = RW'(a);
            mplier_d = b;
            acc_d    = RW'(c);
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc  = acc_q;
    // Step count is fixed at DATASIZE regardless of the multiplier value.
    assign done = step && (cnt_q == CW'(DATASIZE - 1));

endmodule
`default_nettype wire

// File: rtl/math_computer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : math_computer_engine                                      |
// | Purpose  : Accepts an operand triple, computes a*b + c over DATASIZE |
// |            shift-add steps and holds the result until consumed.      |
// | Ports    : clk - rising-edge clock                                   |
// |            rst - asynchronous active-low reset                       |
// |            bus - math_computer_if.slave (operand in, result out)     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module math_computer_engine
    import math_computer_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    math_computer_if.slave  bus
);
    localparam int RW = result_width(DATASIZE);

    state_t        state_q, state_d;
    logic          load, step, done;
    logic          in_ready, out_valid;
    logic [RW-1:0] acc;

    math_computer_mult_seq #(
        .DATASIZE (DATASIZE)
    ) u_mult (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .a    (bus.a),
        .b    (bus.b),
        .c    (bus.c),
        .acc  (acc),
        .done (done)
    );

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is gated by rst so it reads 0 for the whole reset.
                in_ready = rst;
                if (bus.input_valid && rst) begin
                    load    = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                step = 1'b1;
                if (done) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (bus.output_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.input_ready  = in_ready;
    assign bus.output_valid = out_valid;
    // Result is masked to zero whenever it is not being offered.
    assign bus.result       = out_valid ? acc : '0;

endmodule
`default_nettype wire

// File: tb/tb_math_computer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_math_computer_engine                                   |
// | Purpose  : Self-checking bench for math_computer_engine (DATASIZE=8) |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_math_computer_engine;
    import math_computer_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    math_computer_if #(.DATASIZE(N)) bus ();

    math_computer_engine #(.DATASIZE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Model: a queue of pending results, each with the edge number after
    // which it must be offered. Input is accepted only when nothing is
    // pending; result appears N edges after acceptance.
    typedef struct {
        int unsigned val;
        int unsigned rdy;
    } ent_t;

    ent_t        q[$];
    ent_t        ent;
    int unsigned edge_n = 0;
    int unsigned acc_cnt = 0, hs_cnt = 0;
    int unsigned last_acc_edge = 0, last_hs_edge = 0, last_hs_val = 0;
    int unsigned rise_edge = 0;
    bit          prev_ov = 1'b0;
    bit          log_en = 1'b0;
    int unsigned hs_log[$];
    int unsigned hs_edges[$];

    int unsigned m_a, m_b, m_c, m_res;
    bit          m_iv, m_ordy, m_rs, m_pre_valid, m_pre_ready;
    bit          e_ready, e_valid;
    int unsigned e_res;

    initial begin
        forever begin
            @(posedge clk);
            m_iv   = bus.input_valid;
            m_ordy = bus.output_ready;
            m_a    = bus.a;
            m_b    = bus.b;
            m_c    = bus.c;
            m_rs   = rst;
            m_res  = bus.result;
            m_pre_valid = (q.size() != 0) && (edge_n >= q[0].rdy);
            m_pre_ready = (q.size() == 0);
            edge_n++;
            if (!m_rs) begin
                q.delete();
            end else begin
                if (m_pre_valid && m_ordy) begin
                    last_hs_val  = m_res;
                    last_hs_edge = edge_n;
                    hs_cnt++;
                    if (log_en) begin
                        hs_log.push_back(m_res);
                        hs_edges.push_back(edge_n);
                    end
                    void'(q.pop_front());
                end
                if (m_pre_ready && m_iv) begin
                    ent.val = m_a * m_b + m_c;
                    ent.rdy = edge_n + N;
                    q.push_back(ent);
                    acc_cnt++;
                    last_acc_edge = edge_n;
                end
            end
            #1;
            e_ready = rst && (q.size() == 0);
            e_valid = (q.size() != 0) && (edge_n >= q[0].rdy);
            e_res   = e_valid ? q[0].val : 0;
            chk("input_ready", {31'd0, bus.input_ready}, {31'd0, e_ready});
            chk("output_valid", {31'd0, bus.output_valid}, {31'd0, e_valid});
            chk("result", {16'd0, bus.result}, e_res);
            if (bus.output_valid && !prev_ov) rise_edge = edge_n;
            prev_ov = bus.output_valid;
        end
    end

    task automatic wait_acc(input int unsigned prev, input string name);
        int k = 0;
        while (acc_cnt == prev && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (acc_cnt == prev) timeout({name, "_accept"});
    endtask

    task automatic wait_hs(input int unsigned prev, input string name);
        int k = 0;
        while (hs_cnt == prev && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (hs_cnt == prev) timeout({name, "_handshake"});
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input int unsigned exp, input string name);
        int unsigned pa, ph;
        @(negedge clk);
        pa = acc_cnt;
        ph = hs_cnt;
        bus.a = a; bus.b = b; bus.c = c;
        bus.input_valid  = 1'b1;
        bus.output_ready = 1'b1;
        wait_acc(pa, name);
        bus.input_valid = 1'b0;
        wait_hs(ph, name);
        chk({name, "_value"}, last_hs_val, exp);
        chk({name, "_rise_latency"}, rise_edge - last_acc_edge, N);
        chk({name, "_hs_latency"}, last_hs_edge - last_acc_edge, N + 1);
    endtask

    int unsigned sq[$];

    initial begin
        int unsigned pa, ph, prev, sent;
        int k;
        bus.input_valid  = 1'b0;
        bus.output_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.input_ready}, 32'd0);
        chk("rst_valid", {31'd0, bus.output_valid}, 32'd0);
        chk("rst_result", {16'd0, bus.result}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.input_ready}, 32'd1);

        run_op(8'd3,   8'd5,   8'd7,   22,    "basic");
        chk("basic_ready_after", {31'd0, bus.input_ready}, 32'd1);
        run_op(8'd255, 8'd255, 8'd255, 65280, "max");
        run_op(8'd200, 8'd0,   8'd9,   9,     "zero_b");

        // Backpressure with competing input traffic
        @(negedge clk);
        bus.output_ready = 1'b0;
        pa = acc_cnt;
        ph = hs_cnt;
        bus.a = 8'd10; bus.b = 8'd12; bus.c = 8'd3;
        bus.input_valid = 1'b1;
        wait_acc(pa, "bp");
        k = 0;
        while (!bus.output_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!bus.output_valid) timeout("bp_valid_rise");
        for (int i = 0; i < 5; i++) begin
            bus.a = 8'($urandom_range(0, 255));
            bus.b = 8'($urandom_range(0, 255));
            bus.c = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk("bp_valid", {31'd0, bus.output_valid}, 32'd1);
            chk("bp_result", {16'd0, bus.result}, 32'd123);
            chk("bp_ready", {31'd0, bus.input_ready}, 32'd0);
        end
        bus.input_valid  = 1'b0;
        bus.output_ready = 1'b1;
        wait_hs(ph, "bp");
        chk("bp_value", last_hs_val, 32'd123);
        chk("bp_no_accept", acc_cnt, pa + 1);

        // Reset in the middle of a computation
        @(negedge clk);
        pa = acc_cnt;
        ph = hs_cnt;
        bus.a = 8'd9; bus.b = 8'd9; bus.c = 8'd0;
        bus.input_valid = 1'b1;
        wait_acc(pa, "mid_rst");
        bus.input_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.output_valid}, 32'd0);
        chk("mid_rst_result", {16'd0, bus.result}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.input_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready_after", {31'd0, bus.input_ready}, 32'd1);
        repeat (12) @(negedge clk);
        chk("mid_rst_no_stale", hs_cnt, ph);
        run_op(8'd2, 8'd2, 8'd1, 5, "after_rst");

        // Streaming with both handshakes held high
        @(negedge clk);
        sq.delete();
        hs_log.delete();
        hs_edges.delete();
        log_en = 1'b1;
        bus.output_ready = 1'b1;
        bus.a = 8'($urandom_range(0, 255));
        bus.b = 8'($urandom_range(0, 255));
        bus.c = 8'($urandom_range(0, 255));
        sq.push_back(int'(bus.a) * int'(bus.b) + int'(bus.c));
        bus.input_valid = 1'b1;
        prev = acc_cnt;
        sent = 1;
        k = 0;
        while (hs_log.size() < 20 && k < 400) begin
            @(negedge clk);
            k++;
            if (acc_cnt != prev) begin
                prev = acc_cnt;
                if (sent < 20) begin
                    bus.a = 8'($urandom_range(0, 255));
                    bus.b = 8'($urandom_range(0, 255));
                    bus.c = 8'($urandom_range(0, 255));
                    sq.push_back(int'(bus.a) * int'(bus.b) + int'(bus.c));
                    sent++;
                end else begin
                    bus.input_valid = 1'b0;
                end
            end
        end
        bus.input_valid = 1'b0;
        if (hs_log.size() < 20) begin
            timeout("stream_count");
        end else begin
            for (int i = 0; i < 20; i++) begin
                chk($sformatf("stream_val%0d", i), hs_log[i], sq[i]);
                if (i > 0) chk($sformatf("stream_gap%0d", i), hs_edges[i] - hs_edges[i-1], N + 2);
            end
        end
        log_en = 1'b0;

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/math_computer_engine.md
# math_computer_engine

Sequential arithmetic engine that is the responder on the math computer input port and the initiator on the output port. It accepts one operand triple (a, b, c) per transaction through a valid/ready handshake and computes result = a*b + c with an iterative shift-add multiplier. It presents the result on the output port and holds it until the consumer takes it. It is the DUT that the math computer bench and its protocol assertions wrap.

## Interface
Parameters:
- DATASIZE, 8, operand width in bits (≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- input_valid  in  1  producer offers a, b, c
- input_ready  out  1  engine can accept an operand triple
- a  in  DATASIZE  multiplicand, unsigned
- b  in  DATASIZE  multiplier, unsigned
- c  in  DATASIZE  addend, unsigned
- output_valid  out  1  result is available
- output_ready  in  1  consumer accepts result
- result  out  2*DATASIZE  a*b + c, unsigned

## Operation
- FSM states: IDLE, COMPUTE, OUTPUT. Reset state is IDLE.
- IDLE:
  - input_ready = 1.
  - On input_valid & input_ready: capture a and b, set acc = zero-extended c, clear step counter, go to COMPUTE.
- COMPUTE:
  - input_ready = 0 and output_valid = 0.
  - On each edge, step i (0..DATASIZE-1) adds (a << i) to acc when b[i] = 1.
  - The counter increments each step.
  - After step DATASIZE-1, go to OUTPUT.
  - Latency is fixed and does not depend on the values of b.
- OUTPUT:
  - output_valid = 1 and result = acc.
  - On output_valid & output_ready, go to IDLE.
- Width rule: max (2^N-1)^2 + (2^N-1) < 2^(2N), so result never overflows 2*DATASIZE bits. No saturation and no carry-out.
- input_valid, a, b and c are ignored outside IDLE. Operands are sampled only on the acceptance edge.
- Reset (any state, including mid-COMPUTE or OUTPUT): the operation is aborted and no result is emitted.
- Reset values of outputs:
  - input_ready = 0 while rst = 0, and 1 from the first cycle after release.
  - output_valid = 0.
  - result = 0.
- result drives 0 whenever output_valid = 0.

## Timing
- E0 = input acceptance edge.
  - Compute steps occur on E1..E_DATASIZE.
  - output_valid rises right after E_DATASIZE.
  - With output_ready = 1, the output handshake occurs at E_DATASIZE+1.
  - input_ready is 1 again right after that edge.
- Minimum period is DATASIZE+2 cycles per operation. There is no overlap between output hold and new input.
- Backpressure: while output_valid = 1 and output_ready = 0:
  - result and output_valid stay stable;
  - input_ready stays 0.
- output_ready asserted while output_valid = 0 has no effect.
- The output side must satisfy the output-port protocol assertions: valid is not dropped before the handshake, and data is stable while valid is held.

## Structure
- Package math_computer_pkg holds:
  - the state enum type (IDLE, COMPUTE, OUTPUT);
  - the default DATASIZE constant;
  - a result-width function returning 2*DATASIZE.
- One sub-module, math_computer_mult_seq, holds the datapath:
  - captured operands, accumulator and step counter;
  - inputs load/step; output done.
- The top level keeps the FSM and handshake logic.

## Test plan
All scenarios use DATASIZE = 8.
- Basic: a=3, b=5, c=7 accepted at E0 -> output_valid rises after exactly 8 edges; result = 22; handshake at E9; input_ready = 1 after E9.
- Maximum: a=255, b=255, c=255 -> result = 65280 (0xFF00); no overflow.
- Zero multiplier: a=200, b=0, c=9 -> result = 9; latency still 8 cycles.
- Backpressure: output_ready = 0 for 5 cycles after output_valid rises, with new input_valid and changing a/b/c -> result, output_valid = 1 and input_ready = 0 stay stable; the new inputs are not accepted; the result is released on the first output_ready = 1 edge.
- Reset mid-operation: rst = 0 at step 4 of a=9, b=9, c=0 -> output_valid = 0, result = 0, input_ready = 0 during reset and 1 after release; no stale result ever appears; next op a=2, b=2, c=1 -> result = 5.
- Streaming: output_ready tied 1, input_valid tied 1, 20 random triples -> one result every 10 cycles, each equal to a*b+c in input order.
